// File: rtl/tx_clk_pkg.sv
// tx_clk_pkg: shared definitions for the transmit clock bring-up controller.
//   - state_t      : FSM state encoding
//   - DEF_*        : default parameter values for tx_clk_mgr
//   - RETRY_W/MAX  : width and saturation value of the retry counter
package tx_clk_pkg;

    typedef enum logic [1:0] {
        RESET_DCM = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int DEF_RST_PULSE    = 3;
    localparam int DEF_LOCK_TIMEOUT = 4096;
    localparam int DEF_LOCK_STABLE  = 16;
    localparam int DEF_CNT_W        = 13;

    localparam int RETRY_W = 4;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronized output (two destination-clock edges of latency)
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tx_clk_mgr.sv
// tx_clk_mgr: transmit-side clock bring-up controller.
// Pulses the DCM reset, waits for lock (with timeout/retry), requires lock to
// be held for LOCK_STABLE cycles, then releases the TX-domain reset. Any lock
// drop while running re-sequences from the DCM reset.
//   txclk_in   : free-running TX reference clock (only clock)
//   reset      : asynchronous active-high reset
//   dcm_locked : DCM LOCKED, asynchronous, synchronized internally
//   dcm_rst    : DCM reset request
//   tx_reset   : TX-domain reset, high until the clock is qualified
//   tx_ready   : high while running, complement of tx_reset
//   retry_cnt  : lock-timeout retry count, saturating
//   lock_lost  : one-cycle pulse when lock drops while running
module tx_clk_mgr
    import tx_clk_pkg::*;
#(
    parameter int RST_PULSE    = DEF_RST_PULSE,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic               txclk_in,
    input  logic               reset,
    input  logic               dcm_locked,
    output logic               dcm_rst,
    output logic               tx_reset,
    output logic               tx_ready,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               lock_lost
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [RETRY_W-1:0] retry_n;
    logic               lost_n;
    logic               locked_s;

    sync_2ff u_lock_sync (
        .clk (txclk_in),
        .rst (reset),
        .d   (dcm_locked),
        .q   (locked_s)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        retry_n = retry_cnt;
        lost_n  = 1'b0;
        case (state)
            RESET_DCM: begin
                if (cnt == RST_LAST) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end
            end
            WAIT_LOCK: begin
                // lock seen on the last timeout cycle still counts as lock
                if (locked_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_n = RESET_DCM;
                    cnt_n   = '0;
                    if (retry_cnt != RETRY_MAX) retry_n = retry_cnt + 1'b1;
                end
            end
            STABLE: begin
                // a drop restarts the full lock window rather than the DCM
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                cnt_n = cnt;
                if (!locked_s) begin
                    state_n = RESET_DCM;
                    cnt_n   = '0;
                    lost_n  = 1'b1;
                end
            end
            default: begin
                state_n = RESET_DCM;
                cnt_n   = '0;
            end
        endcase
    end

    // outputs decode the next state so they switch on the same edge as state
    always_ff @(posedge txclk_in or posedge reset) begin
        if (reset) begin
            state     <= RESET_DCM;
            cnt       <= '0;
            dcm_rst   <= 1'b1;
            tx_reset  <= 1'b1;
            tx_ready  <= 1'b0;
            retry_cnt <= '0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dcm_rst   <= (state_n == RESET_DCM);
            tx_reset  <= (state_n != RUN);
            tx_ready  <= (state_n == RUN);
            retry_cnt <= retry_n;
            lock_lost <= lost_n;
        end
    end

endmodule

// File: tb/tb_tx_clk_mgr.sv
// tb_tx_clk_mgr: directed self-checking bench for tx_clk_mgr (default params).
// Edges are counted from the bench side; all expected values are hand-derived.
module tb_tx_clk_mgr;

    logic       txclk_in = 1'b0;
    logic       reset    = 1'b1;
    logic       dcm_locked = 1'b0;
    logic       dcm_rst, tx_reset, tx_ready, lock_lost;
    logic [3:0] retry_cnt;

    int total = 0;
    int bad   = 0;

    tx_clk_mgr dut (
        .txclk_in   (txclk_in),
        .reset      (reset),
        .dcm_locked (dcm_locked),
        .dcm_rst    (dcm_rst),
        .tx_reset   (tx_reset),
        .tx_ready   (tx_ready),
        .retry_cnt  (retry_cnt),
        .lock_lost  (lock_lost)
    );

    always #5 txclk_in = ~txclk_in;

    // advance n rising edges, then settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge txclk_in);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(5);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        dcm_locked = 1'b0;
        reset = 1'b1;
        tick(1);
        total++; if (dcm_rst !== 1'b1) begin bad++; $display("FAIL reset_dcm_rst got=%b exp=1", dcm_rst); end
        total++; if (tx_reset !== 1'b1) begin bad++; $display("FAIL reset_tx_reset got=%b exp=1", tx_reset); end
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready got=%b exp=0", tx_ready); end
        total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL reset_retry got=%0d exp=0", retry_cnt); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL reset_lock_lost got=%b exp=0", lock_lost); end
        tick(4);
        reset = 1'b0;
    endtask

    // reset already released by test_reset; S = first edge sampling lock=1
    task automatic test_bring_up();
        tick(1);
        total++; if (dcm_rst !== 1'b1) begin bad++; $display("FAIL bringup_rst_c1 got=%b exp=1", dcm_rst); end
        tick(1);
        total++; if (dcm_rst !== 1'b1) begin bad++; $display("FAIL bringup_rst_c2 got=%b exp=1", dcm_rst); end
        tick(1);
        total++; if (dcm_rst !== 1'b0) begin bad++; $display("FAIL bringup_rst_c3 got=%b exp=0", dcm_rst); end
        total++; if (tx_reset !== 1'b1) begin bad++; $display("FAIL bringup_txrst_wait got=%b exp=1", tx_reset); end
        tick(1);
        dcm_locked = 1'b1;          // sampled on the next edge S
        tick(18);                   // S+17
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL bringup_early_ready got=%b exp=0", tx_ready); end
        tick(1);                    // S+18: 19th edge counting S
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL bringup_ready got=%b exp=1", tx_ready); end
        total++; if (tx_reset !== 1'b0) begin bad++; $display("FAIL bringup_tx_reset got=%b exp=0", tx_reset); end
        total++; if (dcm_rst !== 1'b0) begin bad++; $display("FAIL bringup_dcm_rst got=%b exp=0", dcm_rst); end
        total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL bringup_retry got=%0d exp=0", retry_cnt); end
    endtask

    // starts in RUN at edge B; lock low for the single sample at B+1
    task automatic test_lock_loss();
        int pulses;
        pulses = 0;
        dcm_locked = 1'b0;
        tick(1);
        dcm_locked = 1'b1;
        if (lock_lost) pulses++;
        for (int i = 2; i <= 23; i++) begin
            tick(1);
            if (lock_lost) pulses++;
            if (i == 2) begin
                total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL loss_still_run got=%b exp=1", tx_ready); end
            end
            if (i == 3) begin
                total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL loss_pulse got=%b exp=1", lock_lost); end
                total++; if (tx_reset !== 1'b1) begin bad++; $display("FAIL loss_tx_reset got=%b exp=1", tx_reset); end
                total++; if (dcm_rst !== 1'b1) begin bad++; $display("FAIL loss_dcm_rst got=%b exp=1", dcm_rst); end
                total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL loss_tx_ready got=%b exp=0", tx_ready); end
            end
            if (i == 6) begin
                total++; if (dcm_rst !== 1'b0) begin bad++; $display("FAIL loss_rst_len got=%b exp=0", dcm_rst); end
            end
            if (i == 22) begin
                total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL loss_early_ready got=%b exp=0", tx_ready); end
            end
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL loss_pulse_count got=%0d exp=1", pulses); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL loss_resequence got=%b exp=1", tx_ready); end
        total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL loss_retry got=%0d exp=0", retry_cnt); end
    endtask

    // WAIT_LOCK at edge A; lock samples high A+1..A+10, low A+11, high after
    task automatic test_unstable();
        int rst_seen, ready_early;
        rst_seen = 0;
        ready_early = 0;
        dcm_locked = 1'b0;
        do_reset();
        tick(3);
        dcm_locked = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (i == 10) dcm_locked = 1'b0;
            if (i == 11) dcm_locked = 1'b1;
            if (dcm_rst) rst_seen++;
            if (i < 30 && tx_ready) ready_early++;
        end
        total++; if (rst_seen !== 0) begin bad++; $display("FAIL unstable_dcm_rst cycles_high=%0d exp=0", rst_seen); end
        total++; if (ready_early !== 0) begin bad++; $display("FAIL unstable_early_ready cycles=%0d exp=0", ready_early); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL unstable_ready got=%b exp=1", tx_ready); end
    endtask

    // WAIT_LOCK at edge W; lock first visible to the FSM at cnt=4095
    task automatic test_boundary();
        dcm_locked = 1'b0;
        do_reset();
        tick(3);
        tick(4093);
        dcm_locked = 1'b1;
        tick(2);
        total++; if (dcm_rst !== 1'b0) begin bad++; $display("FAIL bound_pre got=%b exp=0", dcm_rst); end
        tick(1);
        total++; if (dcm_rst !== 1'b0) begin bad++; $display("FAIL bound_no_retry_rst got=%b exp=0", dcm_rst); end
        total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL bound_retry got=%0d exp=0", retry_cnt); end
        tick(15);
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL bound_early_ready got=%b exp=0", tx_ready); end
        tick(1);
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL bound_ready got=%b exp=1", tx_ready); end
    endtask

    task automatic test_timeout_retry();
        int exp_retry;
        dcm_locked = 1'b0;
        do_reset();
        tick(3);
        tick(4095);
        total++; if (dcm_rst !== 1'b0) begin bad++; $display("FAIL retry_pre_rst got=%b exp=0", dcm_rst); end
        total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL retry_pre_cnt got=%0d exp=0", retry_cnt); end
        tick(1);
        total++; if (dcm_rst !== 1'b1) begin bad++; $display("FAIL retry_rst1 got=%b exp=1", dcm_rst); end
        total++; if (retry_cnt !== 4'd1) begin bad++; $display("FAIL retry_cnt1 got=%0d exp=1", retry_cnt); end
        tick(2);
        total++; if (dcm_rst !== 1'b1) begin bad++; $display("FAIL retry_rst3 got=%b exp=1", dcm_rst); end
        tick(1);
        total++; if (dcm_rst !== 1'b0) begin bad++; $display("FAIL retry_rst_end got=%b exp=0", dcm_rst); end
        tick(4096);
        total++; if (retry_cnt !== 4'd2) begin bad++; $display("FAIL retry_cnt2 got=%0d exp=2", retry_cnt); end
        for (int k = 3; k <= 17; k++) begin
            tick(4099);
            exp_retry = (k > 15) ? 15 : k;
            total++; if (retry_cnt !== 4'(exp_retry)) begin bad++; $display("FAIL retry_cnt_k%0d got=%0d exp=%0d", k, retry_cnt, exp_retry); end
        end
    endtask

    // continues right after a timeout edge T (RESET_DCM, cnt=0, retry=15);
    // lock sampled from T+1, STABLE from T+4, cnt=8 after T+12
    task automatic test_async_reset_mid_stable();
        dcm_locked = 1'b1;
        tick(12);
        total++; if (dcm_rst !== 1'b0 || tx_ready !== 1'b0) begin bad++; $display("FAIL areset_pre dcm_rst=%b tx_ready=%b exp=0/0", dcm_rst, tx_ready); end
        total++; if (retry_cnt !== 4'd15) begin bad++; $display("FAIL areset_pre_retry got=%0d exp=15", retry_cnt); end
        #3;
        reset = 1'b1;
        #1;
        total++; if (dcm_rst !== 1'b1) begin bad++; $display("FAIL areset_dcm_rst got=%b exp=1", dcm_rst); end
        total++; if (tx_reset !== 1'b1) begin bad++; $display("FAIL areset_tx_reset got=%b exp=1", tx_reset); end
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL areset_tx_ready got=%b exp=0", tx_ready); end
        total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL areset_retry got=%0d exp=0", retry_cnt); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL areset_lock_lost got=%b exp=0", lock_lost); end
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_bring_up();
        test_lock_loss();
        test_unstable();
        test_boundary();
        test_timeout_retry();
        test_async_reset_mid_stable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
